// File: rtl/jtag_debug_sysclk_bridge_if.sv
// Command handshake between the JTAG sysclk bridge and the debug core.
// The bridge (master) drives the command word and decoded action pulses.
interface jtag_debug_sysclk_bridge_if #(
   parameter int IR_W = 2,
   parameter int DR_W = 38
);
   localparam int NCMD = 2 ** IR_W;

   logic [DR_W-1:0] jdo;
   logic [IR_W-1:0] cmd_ir;
   logic            cmd_valid;
   logic            cmd_ready;
   logic [NCMD-1:0] take_action;
   logic [NCMD-1:0] take_no_action;

   modport master (
      output jdo,
      output cmd_ir,
      output cmd_valid,
      output take_action,
      output take_no_action,
      input  cmd_ready
   );

   modport slave (
      input  jdo,
      input  cmd_ir,
      input  cmd_valid,
      input  take_action,
      input  take_no_action,
      output cmd_ready
   );
endinterface

// File: rtl/jtag_debug_sysclk_bridge.sv
// System-clock side of the CPU JTAG debug bridge: strobe sync,
// command capture, valid/ready issue, action decode and overrun flag.
module jtag_debug_sysclk_bridge #(
   parameter int IR_W        = 2,
   parameter int DR_W        = 38,
   parameter int ACTION_BIT  = 35,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            vs_udr,
   input  logic            vs_uir,
   input  logic [IR_W-1:0] ir_in,
   input  logic [DR_W-1:0] sr,
   input  logic            clr_overrun,
   output logic            ir_update,
   output logic            overrun,
   jtag_debug_sysclk_bridge_if.master cmd_if
);
   localparam int NCMD = 2 ** IR_W;
   localparam int FW   = $clog2(SYNC_STAGES + 1);

   typedef enum logic {
      S_IDLE,
      S_PEND
   } state_e;

   logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
   logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
   logic                   udr_hist_q, udr_hist_d;
   logic                   uir_hist_q, uir_hist_d;
   logic                   udr_rise_q, udr_rise_d;
   logic                   uir_rise_q, uir_rise_d;
   logic [FW-1:0]          fill_q, fill_d;
   logic                   filled;
   logic                   udr_s, uir_s;

   state_e                 state_q, state_d;
   logic [DR_W-1:0]        jdo_q, jdo_d;
   logic [IR_W-1:0]        cmd_ir_q, cmd_ir_d;
   logic [NCMD-1:0]        act_q, act_d;
   logic [NCMD-1:0]        noact_q, noact_d;
   logic [NCMD-1:0]        ir_onehot;
   logic                   ir_update_q, ir_update_d;
   logic                   overrun_q, overrun_d;

   logic                   valid;
   logic                   accept;
   logic                   capture;
   logic                   ovr_set;

   // Until the chains have filled, history is forced high so a strobe
   // already asserted across reset is not mistaken for a fresh edge.
   always_comb begin
      udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_s      = udr_sync_q[SYNC_STAGES-1];
      uir_s      = uir_sync_q[SYNC_STAGES-1];
      filled     = (fill_q == FW'(SYNC_STAGES));
      fill_d     = filled ? fill_q : fill_q + FW'(1);
      udr_hist_d = filled ? udr_s : 1'b1;
      uir_hist_d = filled ? uir_s : 1'b1;
      udr_rise_d = filled & udr_s & ~udr_hist_q;
      uir_rise_d = filled & uir_s & ~uir_hist_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (udr_rise_q) state_d = S_PEND;
         end
         S_PEND: begin
            if (accept && !udr_rise_q) state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      valid   = (state_q == S_PEND);
      accept  = valid & cmd_if.cmd_ready;
      capture = udr_rise_q & (~valid | accept);
      ovr_set = udr_rise_q & valid & ~accept;
   end

   // Decode reads the held word, so a same-cycle capture cannot leak in.
   always_comb begin
      jdo_d    = jdo_q;
      cmd_ir_d = cmd_ir_q;
      if (capture) begin
         jdo_d    = sr;
         cmd_ir_d = ir_in;
      end
      ir_onehot = NCMD'(1) << cmd_ir_q;
      act_d     = '0;
      noact_d   = '0;
      if (accept) begin
         if (jdo_q[ACTION_BIT]) begin
            act_d = ir_onehot;
         end else begin
            noact_d = ir_onehot;
         end
      end
      ir_update_d = uir_rise_q;
      if (ovr_set) begin
         overrun_d = 1'b1;
      end else if (clr_overrun) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         udr_sync_q  <= '0;
         uir_sync_q  <= '0;
         udr_hist_q  <= 1'b0;
         uir_hist_q  <= 1'b0;
         udr_rise_q  <= 1'b0;
         uir_rise_q  <= 1'b0;
         fill_q      <= '0;
         jdo_q       <= '0;
         cmd_ir_q    <= '0;
         act_q       <= '0;
         noact_q     <= '0;
         ir_update_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         udr_sync_q  <= udr_sync_d;
         uir_sync_q  <= uir_sync_d;
         udr_hist_q  <= udr_hist_d;
         uir_hist_q  <= uir_hist_d;
         udr_rise_q  <= udr_rise_d;
         uir_rise_q  <= uir_rise_d;
         fill_q      <= fill_d;
         jdo_q       <= jdo_d;
         cmd_ir_q    <= cmd_ir_d;
         act_q       <= act_d;
         noact_q     <= noact_d;
         ir_update_q <= ir_update_d;
         overrun_q   <= overrun_d;
      end
   end

   assign cmd_if.jdo            = jdo_q;
   assign cmd_if.cmd_ir         = cmd_ir_q;
   assign cmd_if.cmd_valid      = valid;
   assign cmd_if.take_action    = act_q;
   assign cmd_if.take_no_action = noact_q;
   assign ir_update             = ir_update_q;
   assign overrun               = overrun_q;
endmodule
